aibnd_clkgate_seq: RTL and testbench

Sequencer that generates the active-high gate control `en` for the aibnd NOR-based clock gate, where `clkout = ~(clk | en)`. It converts a level request from the adapter/control logic into a glitch-safe gate/ungate sequence. The sequence has a programmable wake settle time before acknowledging the clock as running, and a programmable drain time before gating. It sits directly upstream of the NOR gate and drives its `en` input from a rising-edge flop.

---
 rtl/aibnd_clkgate_seq.sv | 108 ++++++++++
 tb/tb_aibnd_clkgate_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/aibnd_clkgate_seq.sv
// Gate/ungate sequencer for the aibnd NOR clock gate (clkout = ~(clk | en)).
// Every output is a posedge flop, so en only moves while clk is high and the NOR output is already low.
module aibnd_clkgate_seq #(
    parameter int DRAIN_CYC = 4,
    parameter int WAKE_CYC  = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_req,
    input  logic       force_on,
    output logic       en,
    output logic       clk_ack,
    output logic       busy,
    output logic [1:0] state,
    input  logic       vccl_aibnd,
    input  logic       vssl_aibnd
);

    localparam logic [1:0] S_OFF   = 2'b00;
    localparam logic [1:0] S_WAKE  = 2'b01;
    localparam logic [1:0] S_ON    = 2'b10;
    localparam logic [1:0] S_DRAIN = 2'b11;

    // A zero settle time is treated as a single cycle.
    localparam int WAKE_N  = (WAKE_CYC  < 1) ? 1 : WAKE_CYC;
    localparam int DRAIN_N = (DRAIN_CYC < 1) ? 1 : DRAIN_CYC;
    localparam logic [CNT_W-1:0] WAKE_T  = CNT_W'(WAKE_N - 1);
    localparam logic [CNT_W-1:0] DRAIN_T = CNT_W'(DRAIN_N - 1);

    logic             req;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             en_nx;
    logic             ack_nx;
    logic             busy_nx;
    logic             unused_supply;

    assign req           = clk_req | force_on;
    assign unused_supply = vccl_aibnd ^ vssl_aibnd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_OFF;
            cnt     <= '0;
            en      <= 1'b1;
            clk_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            en      <= en_nx;
            clk_ack <= ack_nx;
            busy    <= busy_nx;
        end
    end

    // WAKE always runs to completion; only DRAIN can be cancelled by a new request.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_OFF: begin
                if (req) begin
                    state_nx = S_WAKE;
                    cnt_nx   = '0;
                end
            end
            S_WAKE: begin
                if (cnt == WAKE_T) begin
                    state_nx = S_ON;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_ON: begin
                if (!req) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end
            end
            S_DRAIN: begin
                if (req) begin
                    state_nx = S_ON;
                    cnt_nx   = '0;
                end else if (cnt == DRAIN_T) begin
                    state_nx = S_OFF;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_OFF;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        en_nx   = (state_nx == S_OFF);
        ack_nx  = (state_nx == S_ON);
        busy_nx = (state_nx == S_WAKE) || (state_nx == S_DRAIN);
    end

endmodule

// File: tb/tb_aibnd_clkgate_seq.sv
// Scoreboard bench for aibnd_clkgate_seq: default settle times (dut a) and zero settle times (dut b)
// driven side by side from one directed vector list.
module tb_aibnd_clkgate_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_req = 1'b0;
    logic       force_on = 1'b0;
    logic       en_a, ack_a, busy_a, en_b, ack_b, busy_b;
    logic [1:0] state_a, state_b;
    logic       vccl = 1'b1;
    logic       vssl = 1'b0;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;
    int step_no = 0;

    logic [1:0] exp_q_a[$];
    logic [1:0] exp_q_b[$];
    int         step_q[$];

    always #5 clk = ~clk;

    aibnd_clkgate_seq #(.DRAIN_CYC(4), .WAKE_CYC(2), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .clk_req(clk_req), .force_on(force_on),
        .en(en_a), .clk_ack(ack_a), .busy(busy_a), .state(state_a),
        .vccl_aibnd(vccl), .vssl_aibnd(vssl)
    );

    aibnd_clkgate_seq #(.DRAIN_CYC(0), .WAKE_CYC(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clk_req(clk_req), .force_on(force_on),
        .en(en_b), .clk_ack(ack_b), .busy(busy_b), .state(state_b),
        .vccl_aibnd(vccl), .vssl_aibnd(vssl)
    );

    // Expected outputs after an edge, given the state the spec says we should be in.
    function automatic logic [4:0] expand(input logic [1:0] s);
        return {s, s == 2'b00, s == 2'b10, s[0]};
    endfunction

    // Drive one cycle of inputs and record the state each DUT must hold after the next edge.
    task automatic step(input logic r, input logic q, input logic f,
                        input logic [1:0] sa, input logic [1:0] sb);
        @(negedge clk);
        reset    = r;
        clk_req  = q;
        force_on = f;
        step_no++;
        exp_q_a.push_back(sa);
        exp_q_b.push_back(sb);
        step_q.push_back(step_no);
    endtask

    // Monitor: one output sample per edge, compared against the queued expectation.
    initial begin
        logic [4:0] exp_a, exp_b, act_a, act_b;
        int         sn;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q_a.size() > 0) begin
                exp_a = expand(exp_q_a.pop_front());
                exp_b = expand(exp_q_b.pop_front());
                sn    = step_q.pop_front();
                act_a = {state_a, en_a, ack_a, busy_a};
                act_b = {state_b, en_b, ack_b, busy_b};
                checks++;
                if (act_a !== exp_a) begin
                    failures++;
                    $display("FAIL dut_a step %0d {state,en,ack,busy}: got %b expected %b", sn, act_a, exp_a);
                end
                checks++;
                if (act_b !== exp_b) begin
                    failures++;
                    $display("FAIL dut_b step %0d {state,en,ack,busy}: got %b expected %b", sn, act_b, exp_b);
                end
            end
        end
    end

    // clkout = ~(clk|en) must never emit a high pulse shorter than half a period.
    wire clkout_a = ~(clk | en_a);
    realtime rise_t = 0.0;
    always @(posedge clkout_a) rise_t = $realtime;
    always @(negedge clkout_a) begin
        if ($realtime > 0.0) begin
            checks++;
            if (($realtime - rise_t) < 5.0) begin
                failures++;
                $display("FAIL clkout_pulse width: got %0t expected >= 5", $realtime - rise_t);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with request high, then release: WAKE, ack two edges later.
        step(1,1,0, 0,0); step(1,1,0, 0,0); step(1,1,0, 0,0);
        step(0,1,0, 1,1); step(0,1,0, 1,2); step(0,1,0, 2,2);
        // Drain: en back after four edges (one for dut b).
        step(0,0,0, 3,3); step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 3,0);
        step(0,0,0, 0,0); step(0,0,0, 0,0);
        // Drain cancelled two edges in.
        step(0,1,0, 1,1); step(0,1,0, 1,2); step(0,1,0, 2,2);
        step(0,0,0, 3,3); step(0,0,0, 3,0); step(0,1,0, 2,1); step(0,1,0, 2,2);
        // Request returns on the terminal-count edge of dut a: request wins.
        step(0,0,0, 3,3); step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 3,0);
        step(0,1,0, 2,1); step(0,1,0, 2,2);
        // Same coincidence for dut b, whose first DRAIN edge is terminal.
        step(0,0,0, 3,3); step(0,1,0, 2,2); step(0,1,0, 2,2);
        step(0,0,0, 3,3); step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 0,0);
        // Single-cycle request: WAKE completes, one-cycle ack, then drain.
        step(0,1,0, 1,1); step(0,0,0, 1,2); step(0,0,0, 2,3); step(0,0,0, 3,0);
        step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 3,0); step(0,0,0, 0,0);
        // force_on alone wakes; dropping it while clk_req holds stays ON.
        step(0,0,1, 1,1); step(0,0,1, 1,2); step(0,0,1, 2,2); step(0,1,1, 2,2);
        step(0,1,0, 2,2); step(0,0,0, 3,3); step(0,0,0, 3,0);
        // Reset mid-DRAIN, mid-WAKE and mid-ON.
        step(1,0,0, 0,0); step(0,1,0, 1,1); step(1,1,0, 0,0);
        step(0,1,0, 1,1); step(0,1,0, 1,2); step(0,1,0, 2,2);
        step(1,1,0, 0,0); step(0,0,0, 0,0);
        repeat (3) @(negedge clk);
        done = 1'b1;
        checks++;
        if (exp_q_a.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q_a.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
